// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for alu_mc: the producer drives operations,
// the consumer side of the ALU returns results and status.
interface alu_mc_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic [4:0]      ALUControl;
   logic [2:0]      funct3;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] Result;
   logic            CarryOut;
   logic            Zero;
   logic            DivByZero;
   logic            busy;

   modport master (
      output in_valid, SrcA, SrcB, ALUControl, funct3, out_ready,
      input  in_ready, out_valid, Result, CarryOut, Zero, DivByZero, busy
   );

   modport slave (
      input  in_valid, SrcA, SrcB, ALUControl, funct3, out_ready,
      output in_ready, out_valid, Result, CarryOut, Zero, DivByZero, busy
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply and
// restoring divide, with a valid/ready result port that can stream one op per cycle.
module alu_mc #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input logic     clk,
   input logic     reset,
   alu_mc_if.slave bus
);
   localparam int CNTW = $clog2(XLEN + 1);
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIVU = 5'b00011;
   localparam logic [4:0] OP_REMU = 5'b10001;

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

   state_t          state_r;
   logic [CNTW-1:0] cnt_r;
   // Shared iteration registers: mul uses acc/multiplicand/multiplier,
   // div uses remainder/dividend-becoming-quotient/divisor.
   logic [XLEN-1:0] acc_r;
   logic [XLEN-1:0] opa_r;
   logic [XLEN-1:0] opb_r;
   logic            is_rem_r;
   logic            out_valid_r;
   logic            busy_r;
   logic            carry_r;
   logic            zero_r;
   logic            dbz_r;
   logic [XLEN-1:0] result_r;

   logic            accept_s;
   logic            is_div_s;
   logic            take_div_s;
   logic [XLEN:0]   sum_s;
   logic [XLEN-1:0] mul_acc_s;
   logic [XLEN:0]   rem_shift_s;
   logic [XLEN:0]   rem_diff_s;
   logic [XLEN-1:0] rem_next_s;
   logic [XLEN-1:0] quot_next_s;

   function automatic logic [XLEN-1:0] alu_single(input logic [4:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (op)
         5'b00000: r = a + b;
         5'b00001: r = a - b;
         5'b00011: r = {XLEN{1'b1}};
         5'b00100: r = a << b[SHW-1:0];
         5'b00101: r = a >> b[SHW-1:0];
         5'b00110: r = {a[XLEN-2:0], a[XLEN-1]};
         5'b00111: r = {a[0], a[XLEN-1:1]};
         5'b01000: r = a & b;
         5'b01001: r = a | b;
         5'b01010: r = a ^ b;
         5'b01011: r = ~(a | b);
         5'b01100: r = ~(a & b);
         5'b01101: r = ~(a ^ b);
         5'b01110: r = {{(XLEN-1){1'b0}}, (a > b)};
         5'b01111: r = {{(XLEN-1){1'b0}}, (a == b)};
         5'b10000: r = b;
         5'b10001: r = a;
         default:  r = a + b;
      endcase
      return r;
   endfunction

   function automatic logic zero_sel(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
      logic z;
      case (f3)
         3'b000:  z = (a == b);
         3'b001:  z = (a != b);
         3'b100:  z = ($signed(a) < $signed(b));
         3'b101:  z = ($signed(a) >= $signed(b));
         3'b110:  z = (a < b);
         3'b111:  z = (a >= b);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

   assign bus.in_ready  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
   assign bus.out_valid = out_valid_r;
   assign bus.Result    = result_r;
   assign bus.CarryOut  = carry_r;
   assign bus.Zero      = zero_r;
   assign bus.DivByZero = dbz_r;
   assign bus.busy      = busy_r;

   assign accept_s   = bus.in_valid && bus.in_ready;
   assign is_div_s   = (bus.ALUControl == OP_DIVU) || (bus.ALUControl == OP_REMU);
   assign take_div_s = is_div_s && (bus.SrcB != {XLEN{1'b0}});
   assign sum_s      = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};

   // One shift-add step and one restoring-division step from the current iteration state.
   always_comb begin
      mul_acc_s   = acc_r;
      rem_shift_s = {acc_r, opa_r[XLEN-1]};
      rem_diff_s  = rem_shift_s - {1'b0, opb_r};
      rem_next_s  = rem_shift_s[XLEN-1:0];
      quot_next_s = {opa_r[XLEN-2:0], 1'b0};
      if (opb_r[0]) begin
         mul_acc_s = acc_r + opa_r;
      end else begin
         mul_acc_s = acc_r;
      end
      if (!rem_diff_s[XLEN]) begin
         rem_next_s  = rem_diff_s[XLEN-1:0];
         quot_next_s = {opa_r[XLEN-2:0], 1'b1};
      end else begin
         rem_next_s  = rem_shift_s[XLEN-1:0];
         quot_next_s = {opa_r[XLEN-2:0], 1'b0};
      end
   end

   // Control FSM, iteration datapath and registered result/flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= {CNTW{1'b0}};
         acc_r       <= {XLEN{1'b0}};
         opa_r       <= {XLEN{1'b0}};
         opb_r       <= {XLEN{1'b0}};
         is_rem_r    <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         carry_r     <= 1'b0;
         zero_r      <= 1'b0;
         dbz_r       <= 1'b0;
         result_r    <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  carry_r <= sum_s[XLEN];
                  zero_r  <= zero_sel(bus.funct3, bus.SrcA, bus.SrcB);
                  if ((bus.ALUControl == OP_MUL) || take_div_s) begin
                     state_r     <= (bus.ALUControl == OP_MUL) ? MUL : DIV;
                     busy_r      <= 1'b1;
                     cnt_r       <= CNTW'(XLEN);
                     acc_r       <= {XLEN{1'b0}};
                     opa_r       <= bus.SrcA;
                     opb_r       <= bus.SrcB;
                     is_rem_r    <= (bus.ALUControl == OP_REMU);
                     out_valid_r <= 1'b0;
                     dbz_r       <= 1'b0;
                  end else begin
                     result_r    <= alu_single(bus.ALUControl, bus.SrcA, bus.SrcB);
                     dbz_r       <= is_div_s;
                     out_valid_r <= 1'b1;
                  end
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end else begin
                  out_valid_r <= out_valid_r;
               end
            end
            MUL: begin
               acc_r <= mul_acc_s;
               opa_r <= {opa_r[XLEN-2:0], 1'b0};
               opb_r <= {1'b0, opb_r[XLEN-1:1]};
               cnt_r <= cnt_r - CNTW'(1);
               if (cnt_r == CNTW'(1)) begin
                  result_r    <= mul_acc_s;
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= MUL;
               end
            end
            DIV: begin
               acc_r <= rem_next_s;
               opa_r <= quot_next_s;
               cnt_r <= cnt_r - CNTW'(1);
               if (cnt_r == CNTW'(1)) begin
                  result_r    <= is_rem_r ? rem_next_s : quot_next_s;
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DIV;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at XLEN=32 and XLEN=8 with an expected-result scoreboard.
module tb_alu_mc;
   typedef struct {
      logic [63:0] res;
      logic        c;
      logic        z;
      logic        dbz;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t q32[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   alu_mc_if #(.XLEN(32)) b32 ();
   alu_mc_if #(.XLEN(8))  b8 ();

   alu_mc #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
   alu_mc #(.XLEN(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

   // Reference model written directly from the operation table, on 64-bit values masked to w.
   function automatic exp_t model(input int w, input logic [4:0] op, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input logic [2:0] f3);
      exp_t e;
      logic [63:0] m, a, b, r, sum;
      int sh;
      m = (64'd1 << w) - 64'd1;
      a = a_in & m;
      b = b_in & m;
      sum = a + b;
      sh = int'(b & 64'(w - 1));
      e.c = sum[w];
      e.dbz = 1'b0;
      case (op)
         5'd1:  r = a - b;
         5'd2:  r = a * b;
         5'd3:  if (b == 64'd0) begin r = m; e.dbz = 1'b1; end else r = a / b;
         5'd4:  r = a << sh;
         5'd5:  r = a >> sh;
         5'd6:  r = (a << 1) | (a >> (w - 1));
         5'd7:  r = (a >> 1) | (a << (w - 1));
         5'd8:  r = a & b;
         5'd9:  r = a | b;
         5'd10: r = a ^ b;
         5'd11: r = ~(a | b);
         5'd12: r = ~(a & b);
         5'd13: r = ~(a ^ b);
         5'd14: r = 64'(a > b);
         5'd15: r = 64'(a == b);
         5'd16: r = b;
         5'd17: if (b == 64'd0) begin r = a; e.dbz = 1'b1; end else r = a % b;
         default: r = a + b;
      endcase
      e.res = r & m;
      case (f3)
         3'd0: e.z = (a == b);
         3'd1: e.z = (a != b);
         3'd4: e.z = ($signed(a << (64 - w)) <  $signed(b << (64 - w)));
         3'd5: e.z = ($signed(a << (64 - w)) >= $signed(b << (64 - w)));
         3'd6: e.z = (a < b);
         3'd7: e.z = (a >= b);
         default: e.z = 1'b0;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ov(input bit w8);
      return w8 ? b8.out_valid : b32.out_valid;
   endfunction
   function automatic logic rdy(input bit w8);
      return w8 ? b8.in_ready : b32.in_ready;
   endfunction
   function automatic logic bsy(input bit w8);
      return w8 ? b8.busy : b32.busy;
   endfunction

   // Present one op (caller sits at a negedge), push its expectation at the accept edge.
   task automatic send(input bit w8, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f3);
      int n;
      n = 0;
      if (w8) begin
         b8.ALUControl = op; b8.SrcA = a[7:0]; b8.SrcB = b[7:0]; b8.funct3 = f3; b8.in_valid = 1'b1;
      end else begin
         b32.ALUControl = op; b32.SrcA = a; b32.SrcB = b; b32.funct3 = f3; b32.in_valid = 1'b1;
      end
      while (rdy(w8) !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 64'(n < 100), 64'd1);
      @(posedge clk);
      if (w8) q8.push_back(model(8, op, 64'(a), 64'(b), f3));
      else    q32.push_back(model(32, op, 64'(a), 64'(b), f3));
      @(negedge clk);
      b8.in_valid  = 1'b0;
      b32.in_valid = 1'b0;
      b8.SrcA  = 8'($urandom());  b8.SrcB  = 8'($urandom());  b8.ALUControl  = 5'($urandom());
      b32.SrcA = $urandom();      b32.SrcB = $urandom();      b32.ALUControl = 5'($urandom());
   endtask

   // Wait for the result, checking latency, busy time and in_ready while busy.
   task automatic recv(input bit w8, input string tag, input int exp_wait, input int exp_busy);
      int wait_n, busy_n, rdy_busy;
      exp_t e;
      wait_n = 0; busy_n = 0; rdy_busy = 0;
      b8.out_ready  = 1'b1;
      b32.out_ready = 1'b1;
      while (ov(w8) !== 1'b1 && wait_n < 200) begin
         if (bsy(w8) === 1'b1) busy_n++;
         if (bsy(w8) === 1'b1 && rdy(w8) === 1'b1) rdy_busy++;
         @(negedge clk);
         wait_n++;
      end
      check({tag, "_wait"}, 64'(wait_n), 64'(exp_wait));
      check({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
      check({tag, "_rdy_busy"}, 64'(rdy_busy), 64'd0);
      e.res = 'x; e.c = 1'bx; e.z = 1'bx; e.dbz = 1'bx;
      if (w8 && q8.size() > 0) e = q8.pop_front();
      else if (!w8 && q32.size() > 0) e = q32.pop_front();
      if (w8) begin
         check({tag, "_res"}, 64'(b8.Result), e.res);
         check({tag, "_c"}, 64'(b8.CarryOut), 64'(e.c));
         check({tag, "_z"}, 64'(b8.Zero), 64'(e.z));
         check({tag, "_dbz"}, 64'(b8.DivByZero), 64'(e.dbz));
      end else begin
         check({tag, "_res"}, 64'(b32.Result), e.res);
         check({tag, "_c"}, 64'(b32.CarryOut), 64'(e.c));
         check({tag, "_z"}, 64'(b32.Zero), 64'(e.z));
         check({tag, "_dbz"}, 64'(b32.DivByZero), 64'(e.dbz));
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ov_clear"}, 64'(ov(w8)), 64'd0);
   endtask

   initial begin
      int ov_seen, rdy_low;
      exp_t e;
      logic [31:0] ra, rb;
      logic [4:0] ops[14];
      ops = '{5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd31};
      b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.SrcA = 32'd0; b32.SrcB = 32'd0;
      b32.ALUControl = 5'd0; b32.funct3 = 3'd0;
      b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.SrcA = 8'd0; b8.SrcB = 8'd0;
      b8.ALUControl = 5'd0; b8.funct3 = 3'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ov", 64'(b32.out_valid), 64'd0);
      check("rst_res", 64'(b32.Result), 64'd0);
      check("rst_busy", 64'(b32.busy), 64'd0);
      check("rst_flags", 64'({b32.CarryOut, b32.Zero, b32.DivByZero}), 64'd0);
      reset = 1'b0;
      check("rst_ready", 64'(b32.in_ready), 64'd1);

      send(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0);   recv(1'b0, "add_carry", 0, 0);
      send(1'b0, 5'd2, 32'h0000_FFFF, 32'h0001_0001, 3'd0);   recv(1'b0, "mul32", 32, 32);
      send(1'b0, 5'd3, 32'h0000_0064, 32'h0000_0007, 3'd0);   recv(1'b0, "divu32", 32, 32);
      send(1'b0, 5'd17, 32'h0000_0064, 32'h0000_0007, 3'd0);  recv(1'b0, "remu32", 32, 32);
      send(1'b0, 5'd3, 32'h0000_0005, 32'h0000_0000, 3'd0);   recv(1'b0, "divu_z", 0, 0);
      send(1'b0, 5'd17, 32'h0000_0005, 32'h0000_0000, 3'd0);  recv(1'b0, "remu_z", 0, 0);
      send(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd4);   recv(1'b0, "slt", 0, 0);
      send(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd6);   recv(1'b0, "sltu", 0, 0);
      send(1'b0, 5'd2, $urandom(), $urandom(), 3'd7);          recv(1'b0, "mul_rnd", 32, 32);

      for (int i = 0; i < 14; i++) begin
         ra = $urandom();
         rb = (i % 3 == 0) ? ra : $urandom();
         send(1'b0, ops[i], ra, rb, 3'($urandom()));
         recv(1'b0, $sformatf("op%0d", ops[i]), 0, 0);
      end

      // Back-pressure: result must hold and no new op may enter.
      b32.out_ready = 1'b0;
      send(1'b0, 5'd10, 32'hA5A5_0F0F, 32'h0FF0_1234, 3'd1);
      e = q32[0];
      for (int i = 0; i < 5; i++) begin
         check("hold_ov", 64'(b32.out_valid), 64'd1);
         check("hold_res", 64'(b32.Result), e.res);
         check("hold_rdy", 64'(b32.in_ready), 64'd0);
         @(negedge clk);
      end
      recv(1'b0, "hold_rel", 0, 0);

      // Four back-to-back xors with the consumer always ready.
      b32.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            check("strm_ov", 64'(b32.out_valid), 64'd1);
            e.res = 'x;
            if (q32.size() > 0) e = q32.pop_front();
            check("strm_res", 64'(b32.Result), e.res);
         end
         if (i < 4) begin
            check("strm_rdy", 64'(b32.in_ready), 64'd1);
            ra = $urandom(); rb = $urandom();
            b32.ALUControl = 5'd10; b32.SrcA = ra; b32.SrcB = rb; b32.funct3 = 3'd0;
            b32.in_valid = 1'b1;
         end else begin
            b32.in_valid = 1'b0;
         end
         @(posedge clk);
         if (i < 4) q32.push_back(model(32, 5'd10, 64'(ra), 64'(rb), 3'd0));
         @(negedge clk);
      end
      check("strm_end", 64'(b32.out_valid), 64'd0);

      // Reset part-way through a division abandons it.
      send(1'b0, 5'd3, 32'h1234_5678, 32'h0000_0013, 3'd0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q32.delete();
      check("rstdiv_rdy", 64'(b32.in_ready), 64'd1);
      check("rstdiv_busy", 64'(b32.busy), 64'd0);
      ov_seen = 0; rdy_low = 0;
      for (int i = 0; i < 40; i++) begin
         if (b32.out_valid !== 1'b0) ov_seen++;
         if (b32.in_ready !== 1'b1) rdy_low++;
         @(negedge clk);
      end
      check("rstdiv_noov", 64'(ov_seen), 64'd0);
      check("rstdiv_rdylow", 64'(rdy_low), 64'd0);

      // Narrow instance.
      send(1'b1, 5'd2, 32'hFF, 32'hFF, 3'd0);    recv(1'b1, "mul8", 8, 8);
      send(1'b1, 5'd0, 32'hFF, 32'h01, 3'd0);    recv(1'b1, "add8", 0, 0);
      send(1'b1, 5'd3, 32'h64, 32'h07, 3'd0);    recv(1'b1, "divu8", 8, 8);
      send(1'b1, 5'd17, 32'h64, 32'h07, 3'd0);   recv(1'b1, "remu8", 8, 8);
      send(1'b1, 5'd3, 32'h05, 32'h00, 3'd0);    recv(1'b1, "divz8", 0, 0);
      send(1'b1, 5'd0, 32'hFF, 32'h01, 3'd4);    recv(1'b1, "slt8", 0, 0);
      send(1'b1, 5'd0, 32'hFF, 32'h01, 3'd6);    recv(1'b1, "sltu8", 0, 0);
      send(1'b1, 5'd4, 32'h81, 32'h0B, 3'd5);    recv(1'b1, "sll8", 0, 0);
      send(1'b1, 5'd7, 32'h81, 32'h00, 3'd7);    recv(1'b1, "ror8", 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
- REQ-001: Parameter XLEN, default 32: operand and result width; legal values are 8, 16, 32 and 64.
- REQ-002: Parameter SHW, default $clog2(XLEN): shift-amount width.
- REQ-003: clk  input  1  the block's one clock; all state updates on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
- REQ-005: in_valid  input  1  the operation on SrcA/SrcB/ALUControl/funct3 is presented.
- REQ-006: in_ready  output  1  the block accepts an operation this cycle.
- REQ-007: SrcA, SrcB  input  XLEN each  operands.
- REQ-008: ALUControl  input  5  operation select; encoding in REQ-014.
- REQ-009: funct3  input  3  branch-compare select; encoding in REQ-016.
- REQ-010: out_valid  output  1  Result and the flags are valid.
- REQ-011: out_ready  input  1  the consumer takes the result.
- REQ-012: Result  output  XLEN; CarryOut  output  1; Zero  output  1; DivByZero  output  1.
- REQ-013: busy  output  1  a multi-cycle operation is in progress.

Function
- REQ-014: ALUControl encoding:
  - 00000 add; 00001 sub; 00010 mul (low XLEN bits, unsigned); 00011 divu.
  - 00100 SrcA<<SrcB[SHW-1:0]; 00101 logical right shift by SrcB[SHW-1:0].
  - 00110 rotate left by 1; 00111 rotate right by 1.
  - 01000 and; 01001 or; 01010 xor; 01011 nor; 01100 nand; 01101 xnor.
  - 01110 unsigned greater-than, result 1/0; 01111 equal, result 1/0.
  - 10000 pass SrcB; 10001 remu.
  - Any other code: add.
- REQ-015: CarryOut shall be bit XLEN of the (XLEN+1)-bit sum {0,SrcA}+{0,SrcB}, regardless of operation.
- REQ-016: Zero shall be selected by funct3 as follows; any other funct3 gives Zero=0.
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
- REQ-017: An operation is accepted on a rising edge where in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
- REQ-018: The FSM shall have the states IDLE, MUL and DIV.
  - IDLE→MUL on accept of mul.
  - IDLE→DIV on accept of divu/remu with SrcB!=0.
  - All other accepts stay in IDLE.
- REQ-019: Single-cycle operations, and divu/remu with SrcB==0, shall register Result, CarryOut and Zero at the accept edge; out_valid=1 on the following cycle (latency 1).
- REQ-020: mul shall be an iterative shift-add, one multiplier bit per cycle, with an internal counter loaded with XLEN at accept.
  - Result is registered and out_valid set at the edge where the counter reaches 0 (latency XLEN); the FSM returns to IDLE on that edge.
- REQ-021: divu/remu shall be a restoring division, one quotient bit per cycle, with the same XLEN-cycle latency and completion rule as mul.
  - divu returns the quotient; remu returns the remainder.
- REQ-022: Division by zero shall return Result = all ones for divu and Result = SrcA for remu, with DivByZero=1, at latency 1; DivByZero=0 for every other result.
- REQ-023: Operands, ALUControl and funct3 shall be captured at the accept edge; input changes after acceptance shall not affect the result.
- REQ-024: busy shall be 1 exactly while the state is MUL or DIV; in_ready shall be 0 while busy.
- REQ-025: While out_valid && !out_ready, Result and all flags shall hold stable and no new operation is accepted.
- REQ-026: out_valid shall clear on the edge where out_ready=1, unless a new single-cycle operation is accepted on the same edge, in which case out_valid stays 1 with the new result (back-to-back throughput of 1 per cycle).
- REQ-027: A completing multi-cycle operation shall not be blocked by out_ready: out_valid is guaranteed 0 at its start by REQ-017.

Reset
- REQ-028: When reset=1 at a rising edge, the following shall be cleared: state=IDLE, out_valid=0, busy=0, Result=0, CarryOut=0, Zero=0, DivByZero=0, and the iteration counter.
- REQ-029: A reset during MUL or DIV shall abandon the operation; no out_valid follows.
- REQ-030: in_ready shall be 1 on the first cycle after reset deasserts.
- REQ-031: reset shall take priority over accept on the same edge.

Verification (XLEN=32 unless stated)
- REQ-032: add, SrcA=FFFFFFFF, SrcB=00000001, funct3=000 → Result=00000000, CarryOut=1, Zero=0, out_valid 1 cycle after accept.
- REQ-033: mul, 0000FFFF×00010001 → Result=FFFFFFFF after exactly 32 cycles, busy=1 for 32 cycles, in_ready=0 throughout.
- REQ-034: Division cases:
  - divu 00000064/00000007 → 0000000E.
  - remu of the same operands → 00000002.
  - divu 5/0 → FFFFFFFF with DivByZero=1 at latency 1.
- REQ-035: funct3=100 with SrcA=FFFFFFFF, SrcB=00000001 → Zero=1; funct3=110 with the same operands → Zero=0.
- REQ-036: Hold out_ready=0 for 5 cycles after a result → Result stable, in_ready=0. Then stream 4 back-to-back xors with out_ready=1 → 4 results on 4 consecutive cycles.
- REQ-037: Assert reset at cycle 10 of a divu → out_valid never rises, in_ready=1 on the cycle after reset deasserts. Repeat the directed tests with XLEN=8: mul FF×FF → 01 after 8 cycles.
